// File: rtl/noc_fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO front end: router valid/ready input plus FIFO write port.
// master = environment (router + FIFO write stage), slave = noc_fifo_wr_ctrl.
interface noc_fifo_wr_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              wfull;
  logic              winc;
  logic [DATA_W:0]   wdata;

  modport master (
    output in_valid, in_data, in_last, wfull,
    input  in_ready, winc, wdata
  );

  modport slave (
    input  in_valid, in_data, in_last, wfull,
    output in_ready, winc, wdata
  );
endinterface

// File: rtl/noc_fifo_wr_ctrl.sv
// Async FIFO write-domain front end: 2-entry skid buffer, full-throttled write strobe, packet framing.
// Optional statistics counters are built when NOC_FIFO_WR_STATS_EN is defined.
module noc_fifo_wr_ctrl #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_PKT_FLITS = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                wclk,
  input  logic                wrst,
  noc_fifo_wr_ctrl_if.slave   bus,
  output logic                pkt_open,
  output logic                err_len,
  output logic [CNT_W-1:0]    flit_cnt,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned LEN_W  = $clog2(MAX_PKT_FLITS) + 1;
  localparam int unsigned WORD_W = DATA_W + 1;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } state_e;

  logic [WORD_W-1:0] ent0_q, ent0_d;
  logic [WORD_W-1:0] ent1_q, ent1_d;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q;
  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;

  logic              push;
  logic              pop;
  logic              force_last;
  logic              last_eff;
  logic [1:0]        slot;

  // Skid buffer next state; ent0 is always the oldest entry.
  always_comb begin
    push       = bus.in_valid & in_ready_q;
    pop        = (count_q != 2'd0) & ~bus.wfull;
    force_last = 1'b0;
    if (!bus.in_last) begin
      if (state_q == HEAD) begin
        force_last = (MAX_PKT_FLITS <= 32'd1);
      end else begin
        force_last = ((32'(len_q) + 32'd1) >= MAX_PKT_FLITS);
      end
    end
    last_eff = bus.in_last | force_last;
    count_d  = count_q + 2'(push) - 2'(pop);
    slot     = count_q - 2'(pop);
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    if (pop) begin
      ent0_d = ent1_q;
    end
    if (push) begin
      if (slot == 2'd0) begin
        ent0_d = {last_eff, bus.in_data};
      end else begin
        ent1_d = {last_eff, bus.in_data};
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      ent0_q     <= '0;
      ent1_q     <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      count_q    <= count_d;
      in_ready_q <= (count_d < 2'd2);
    end
  end

  // Framing FSM; a too-long packet is cut by forcing the tail bit on the limit flit.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= HEAD;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else if (push) begin
      if (force_last) begin
        err_q <= 1'b1;
      end
      case (state_q)
        HEAD: begin
          if (!last_eff) begin
            state_q <= BODY;
            len_q   <= LEN_W'(1);
          end
        end
        BODY: begin
          if (last_eff) begin
            state_q <= HEAD;
          end else begin
            len_q <= len_q + LEN_W'(1);
          end
        end
        default: state_q <= HEAD;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.winc     = pop;
  assign bus.wdata    = (count_q != 2'd0) ? ent0_q : '0;
  assign pkt_open     = (state_q == BODY);
  assign err_len      = err_q;

`ifdef NOC_FIFO_WR_STATS_EN
  logic [CNT_W-1:0] flit_cnt_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      flit_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) begin
        flit_cnt_q <= flit_cnt_q + CNT_W'(1);
      end
      if (pop & ent0_q[DATA_W]) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
      if ((count_q != 2'd0) & bus.wfull) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign flit_cnt  = flit_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign flit_cnt  = '0;
  assign pkt_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_fifo_wr_ctrl.sv
// Bench for noc_fifo_wr_ctrl: hand-built vector table, corner sequences and random traffic vs a queue model.
module tb_noc_fifo_wr_ctrl;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MAX_PKT = 4;
  localparam int unsigned CNT_W   = 16;

  logic             wclk = 1'b0;
  logic             wrst;
  logic             pkt_open;
  logic             err_len;
  logic [CNT_W-1:0] flit_cnt;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] stall_cnt;

  noc_fifo_wr_ctrl_if #(.DATA_W(DATA_W)) bus ();

  noc_fifo_wr_ctrl #(
    .DATA_W(DATA_W),
    .MAX_PKT_FLITS(MAX_PKT),
    .CNT_W(CNT_W)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .bus(bus.slave),
    .pkt_open(pkt_open),
    .err_len(err_len),
    .flit_cnt(flit_cnt),
    .pkt_cnt(pkt_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: buffer contents as a queue, packet length as a plain count.
  logic [DATA_W:0] mq[$];
  bit              m_ready;
  bit              m_err;
  bit              m_known = 1'b0;
  int              pl;
  int unsigned     m_flit;
  int unsigned     m_pkt;
  int unsigned     m_stall;

  typedef struct {
    logic            v;
    logic [7:0]      d;
    logic            l;
    logic            f;
    logic            rdy;
    logic            wi;
    logic [8:0]      wd;
    logic            op;
    logic            er;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic sample_check();
    logic [DATA_W:0] ew;
    #4;
    if (m_known) begin
      ew = (mq.size() != 0) ? mq[0] : '0;
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("winc", 32'(bus.winc), 32'((mq.size() != 0) && !bus.wfull));
      chk("wdata", 32'(bus.wdata), 32'(ew));
      chk("pkt_open", 32'(pkt_open), 32'(pl != 0));
      chk("err_len", 32'(err_len), 32'(m_err));
`ifdef NOC_FIFO_WR_STATS_EN
      chk("flit_cnt", 32'(flit_cnt), 32'(CNT_W'(m_flit)));
      chk("pkt_cnt", 32'(pkt_cnt), 32'(CNT_W'(m_pkt)));
      chk("stall_cnt", 32'(stall_cnt), 32'(CNT_W'(m_stall)));
`else
      chk("cnt_tied", 32'(flit_cnt | pkt_cnt | stall_cnt), 32'd0);
`endif
    end
  endtask

  task automatic advance();
    bit pop;
    bit acc;
    bit lf;
    if (wrst) begin
      mq.delete();
      m_ready = 1'b0;
      m_err   = 1'b0;
      pl      = 0;
      m_flit  = 0;
      m_pkt   = 0;
      m_stall = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      pop = (mq.size() != 0) && !bus.wfull;
      acc = bus.in_valid && m_ready;
      if ((mq.size() != 0) && bus.wfull) m_stall++;
      if (pop) begin
        m_flit++;
        if (mq[0][DATA_W]) m_pkt++;
        void'(mq.pop_front());
      end
      if (acc) begin
        lf = bus.in_last;
        pl++;
        if (!lf && pl >= int'(MAX_PKT)) begin
          lf    = 1'b1;
          m_err = 1'b1;
        end
        if (lf) pl = 0;
        mq.push_back({lf, bus.in_data});
      end
      m_ready = (mq.size() < 2);
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic cycle();
    sample_check();
    advance();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.wfull    = f;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    wrst = 1'b1;
    cycle();
    wrst = 1'b0;
    sample_check();
    chk("rst_ready_low", 32'(bus.in_ready), 32'd0);
    chk("rst_winc", 32'(bus.winc), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    advance();
  endtask

  initial begin
    logic hold;
    tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0A0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0A1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0A2, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1A3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h1B0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1B0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1B0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 9'h1B1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1B2, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0C0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0C1, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0C2, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1C3, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 8'hC5, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0C4, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0C5, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 1'b1};

    wrst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    do_reset();

    // Packet, full back-pressure and over-length packet, hand-derived expectations.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f);
      sample_check();
      chk($sformatf("tbl%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_winc", i), 32'(bus.winc), 32'(tbl[i].wi));
      chk($sformatf("tbl%0d_wdata", i), 32'(bus.wdata), 32'(tbl[i].wd));
      chk($sformatf("tbl%0d_open", i), 32'(pkt_open), 32'(tbl[i].op));
      chk($sformatf("tbl%0d_err", i), 32'(err_len), 32'(tbl[i].er));
      advance();
    end
`ifdef NOC_FIFO_WR_STATS_EN
    chk("tbl_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("tbl_flit_cnt", 32'(flit_cnt), 32'd13);
`endif

    // Reset mid-packet with two flits buffered.
    do_reset();
    drive(1'b1, 8'hD0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 8'hD1, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid_open_before", 32'(pkt_open), 32'd1);
    wrst = 1'b1;
    cycle();
    wrst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    sample_check();
    chk("mid_rst_winc", 32'(bus.winc), 32'd0);
    chk("mid_rst_open", 32'(pkt_open), 32'd0);
    chk("mid_rst_err", 32'(err_len), 32'd0);
    advance();
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) cycle();

    // 20-flit continuous stream.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i + 16), 1'(i % 4 == 3), 1'b0);
      sample_check();
      chk("stream_ready", 32'(bus.in_ready), 32'd1);
      advance();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
`ifdef NOC_FIFO_WR_STATS_EN
    chk("stream_flit_cnt", 32'(flit_cnt), 32'd20);
`endif

    // Back-to-back single-flit packets.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(i + 8'h50), 1'b1, 1'b0);
      cycle();
      chk("single_open", 32'(pkt_open), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    chk("single_err", 32'(err_len), 32'd0);
`ifdef NOC_FIFO_WR_STATS_EN
    chk("single_pkt_cnt", 32'(pkt_cnt), 32'd5);
`endif

    // Random traffic; a pending flit is held until accepted.
    do_reset();
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = 8'($urandom);
        bus.in_last  = ($urandom_range(0, 4) == 0);
      end
      bus.wfull = ($urandom_range(0, 3) == 0);
      hold = bus.in_valid && !m_ready;
      cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
